// File: rtl/led_pkg.sv
// Shared constants and types for the LED fader.
// Provides the default LED count, PWM width and step divider, and the
// brightness level type used at the default configuration.
package led_pkg;

  localparam int LED_N        = 4;
  localparam int LED_PWM_BITS = 8;
  localparam int LED_STEP_DIV = 65536;

  typedef logic [LED_PWM_BITS-1:0] led_level_t;

endpackage

// File: rtl/led_fade_channel.sv
// One LED channel of the fader: a brightness level that ramps one step per
// tick toward its target, a shadow copy of the level that only changes at
// PWM period boundaries, and the registered PWM comparator.
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   tick       : ramp step strobe (one cycle)
//   pb         : PWM period boundary strobe (pwm_cnt at its maximum)
//   pwm_cnt    : shared free-running PWM counter
//   target     : brightness this channel should settle at
//   level      : current ramp level
//   led_out    : registered PWM drive for this LED
module led_fade_channel
  import led_pkg::*;
#(
  parameter int PWM_BITS = LED_PWM_BITS
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                tick,
  input  logic                pb,
  input  logic [PWM_BITS-1:0] pwm_cnt,
  input  logic [PWM_BITS-1:0] target,
  output logic [PWM_BITS-1:0] level,
  output logic                led_out
);

  logic [PWM_BITS-1:0] shadow;

  // NOTE: sequential state uses non-blocking assignments, so every right-hand
  // side below reads the value from before this edge. That is what makes the
  // shadow take the pre-update level when tick and pb coincide.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      level   <= '0;
      shadow  <= '0;
      led_out <= 1'b0;
    end else begin
      // Single-step ramp: a target change mid-ramp simply flips direction.
      if (tick) begin
        if (level < target)      level <= level + 1'b1;
        else if (level > target) level <= level - 1'b1;
      end
      // Compare value only moves at the period boundary, so no period is cut.
      if (pb) shadow <= level;
      led_out <= (pwm_cnt < shadow);
    end
  end

endmodule

// File: rtl/led_fader.sv
// LED fader: turns an on/off LED request pattern into PWM drive that fades
// smoothly between off and a programmable brightness.
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   led_req    : requested on/off pattern, bit i turns LED i on
//   enable     : 0 fades every channel out
//   max_level  : brightness an "on" channel fades to
//   led_out    : registered PWM drive to the LED pins
//   fade_busy  : registered, high while any channel is away from its target
module led_fader
  import led_pkg::*;
#(
  parameter int N_LEDS   = LED_N,
  parameter int PWM_BITS = LED_PWM_BITS,
  parameter int STEP_DIV = LED_STEP_DIV
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [N_LEDS-1:0]   led_req,
  input  logic                enable,
  input  logic [PWM_BITS-1:0] max_level,
  output logic [N_LEDS-1:0]   led_out,
  output logic                fade_busy
);

  localparam int STEP_W = (STEP_DIV > 2) ? $clog2(STEP_DIV) : 1;
  localparam logic [STEP_W-1:0] STEP_RELOAD = STEP_W'(STEP_DIV - 1);

  logic [PWM_BITS-1:0] pwm_cnt;
  logic [STEP_W-1:0]   step_cnt;
  logic                tick;
  logic                pb;
  logic [PWM_BITS-1:0] target [N_LEDS];
  logic [PWM_BITS-1:0] level  [N_LEDS];
  logic                busy_next;

  assign tick = (step_cnt == '0);
  assign pb   = &pwm_cnt;

  // NOTE: every variable written here gets a value on every path (the busy
  // default comes first), so no latch is inferred.
  always_comb begin
    busy_next = 1'b0;
    for (int i = 0; i < N_LEDS; i++) begin
      target[i] = (enable && led_req[i]) ? max_level : '0;
      busy_next = busy_next | (level[i] != target[i]);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pwm_cnt   <= '0;
      step_cnt  <= STEP_RELOAD;
      fade_busy <= 1'b0;
    end else begin
      pwm_cnt   <= pwm_cnt + 1'b1;
      step_cnt  <= tick ? STEP_RELOAD : step_cnt - 1'b1;
      fade_busy <= busy_next;
    end
  end

  for (genvar g = 0; g < N_LEDS; g++) begin : g_ch
    led_fade_channel #(
      .PWM_BITS(PWM_BITS)
    ) u_ch (
      .clk     (clk),
      .reset   (reset),
      .tick    (tick),
      .pb      (pb),
      .pwm_cnt (pwm_cnt),
      .target  (target[g]),
      .level   (level[g]),
      .led_out (led_out[g])
    );
  end

endmodule
